// File: rtl/mmem_ctl.sv
// mmem_ctl -- M-memory controller for the CADR datapath.
//
// Steers the single M-memory RAM port between source reads and a small
// posted write buffer. Reads always win the port; buffered writes drain
// one per cycle whenever no read is requested. A read compares its address
// against every buffered write (and a write being accepted in the same
// cycle) so the M bus always sees the newest value, even before it reaches
// the RAM.
//
// Parameters:
//   AW   - M-memory address width (depth 2**AW)
//   DW   - M-memory data width
//   WBUF - write buffer depth (>= 1)
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   state_decode      - M-source read requested this cycle
//   state_write       - write slot
//   ir_msel, ir_madr  - source select (0 = M) and M source address
//   destm             - current instruction targets M memory
//   wadr, wdata       - write address and data
//   srcm, mpassm      - decoded M-source select
//   mem_adr, mem_rp, mem_wp, mem_wdata, mem_rdata - RAM port
//   mdata, mdata_vld  - bypass-corrected read data, one cycle after the read
//   wbuf_count, wbuf_full - write buffer occupancy
//   stall             - write request refused this cycle; requester holds
module mmem_ctl #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int WBUF = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      state_decode,
    input  logic                      state_write,
    input  logic                      ir_msel,
    input  logic [AW-1:0]             ir_madr,
    input  logic                      destm,
    input  logic [AW-1:0]             wadr,
    input  logic [DW-1:0]             wdata,
    output logic                      srcm,
    output logic                      mpassm,
    output logic [AW-1:0]             mem_adr,
    output logic                      mem_rp,
    output logic                      mem_wp,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata,
    output logic [DW-1:0]             mdata,
    output logic                      mdata_vld,
    output logic [$clog2(WBUF+1)-1:0] wbuf_count,
    output logic                      wbuf_full,
    output logic                      stall
);

    localparam int CW = $clog2(WBUF + 1);
    localparam int PW = (WBUF > 1) ? $clog2(WBUF) : 1;

    logic [AW-1:0] addrQ [WBUF];
    logic [DW-1:0] dataQ [WBUF];
    logic [PW-1:0] headQ, headD;
    logic [PW-1:0] tailQ, tailD;
    logic [CW-1:0] countQ, countD;

    logic          vldQ;
    logic          hitQ;
    logic [DW-1:0] hitDataQ;
    logic          hitD;
    logic [DW-1:0] hitDataD;

    logic          wrReq;
    logic          accept;
    logic          drain;

    assign srcm   = ~ir_msel;
    assign mpassm = ~ir_msel;

    assign wbuf_count = countQ;
    assign wbuf_full  = (countQ == CW'(WBUF));

    // A full buffer only refuses a write when a read also holds the port;
    // otherwise the head drains in the same cycle and frees the slot.
    assign wrReq  = state_write & destm;
    assign stall  = wbuf_full & wrReq & state_decode;
    assign accept = wrReq & ~stall;
    assign drain  = ~state_decode & (countQ != '0);

    assign mem_rp    = state_decode;
    assign mem_wp    = drain;
    assign mem_adr   = drain ? addrQ[headQ] : ir_madr;
    assign mem_wdata = dataQ[headQ];

    assign mdata_vld = vldQ;
    assign mdata     = vldQ ? (hitQ ? hitDataQ : mem_rdata) : '0;

    // Pointer and count bookkeeping; pointers wrap at WBUF, which need not
    // be a power of two.
    always_comb begin
        headD  = headQ;
        tailD  = tailQ;
        countD = countQ + CW'(accept) - CW'(drain);
        if (drain) begin
            headD = (headQ == PW'(WBUF - 1)) ? '0 : headQ + 1'b1;
        end
        if (accept) begin
            tailD = (tailQ == PW'(WBUF - 1)) ? '0 : tailQ + 1'b1;
        end
    end

    // Bypass search walks from head (oldest) to tail (newest) so later
    // matches override earlier ones; a same-cycle enqueue is newer still.
    always_comb begin
        hitD     = 1'b0;
        hitDataD = '0;
        for (int i = 0; i < WBUF; i++) begin
            logic [PW:0]   sum;
            logic [PW-1:0] idx;
            sum = {1'b0, headQ} + (PW+1)'(i);
            if (sum >= (PW+1)'(WBUF)) begin
                sum = sum - (PW+1)'(WBUF);
            end
            idx = sum[PW-1:0];
            if ((CW'(i) < countQ) && (addrQ[idx] == ir_madr)) begin
                hitD     = 1'b1;
                hitDataD = dataQ[idx];
            end
        end
        if (accept && (wadr == ir_madr)) begin
            hitD     = 1'b1;
            hitDataD = wdata;
        end
    end

    // Control state: pointers, occupancy and the registered read result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headQ    <= '0;
            tailQ    <= '0;
            countQ   <= '0;
            vldQ     <= 1'b0;
            hitQ     <= 1'b0;
            hitDataQ <= '0;
        end else begin
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
            vldQ   <= state_decode;
            hitQ   <= state_decode & hitD;
            if (state_decode) begin
                hitDataQ <= hitDataD;
            end
        end
    end

    // Entry storage needs no reset: slots are only observed while the
    // occupancy count covers them.
    always_ff @(posedge clk) begin
        if (accept) begin
            addrQ[tailQ] <= wadr;
            dataQ[tailQ] <= wdata;
        end
    end

endmodule

// File: tb/tb_mmem_ctl.sv
// tb_mmem_ctl -- directed bench for mmem_ctl.
//
// Two instances share all inputs: dutA uses the default two-entry buffer
// and carries the reset, read, bypass and stall scenarios; dutB uses a
// three-entry buffer and carries the pointer wrap scenario. Each instance
// has its own RAM model.
module tb_mmem_ctl;

    logic        clk;
    logic        reset;
    logic        stateDecode;
    logic        stateWrite;
    logic        irMsel;
    logic [4:0]  irMadr;
    logic        destm;
    logic [4:0]  wadr;
    logic [31:0] wdata;

    logic        srcmA, mpassmA, memRpA, memWpA, mdataVldA, wbufFullA, stallA;
    logic [4:0]  memAdrA;
    logic [31:0] memWdataA, memRdataA, mdataA;
    logic [1:0]  wbufCountA;

    logic        srcmB, mpassmB, memRpB, memWpB, mdataVldB, wbufFullB, stallB;
    logic [4:0]  memAdrB;
    logic [31:0] memWdataB, memRdataB, mdataB;
    logic [1:0]  wbufCountB;

    logic [31:0] ramA [0:31];
    logic [31:0] ramB [0:31];

    int checkCount = 0;
    int failCount  = 0;
    int cntModel   = 0;

    mmem_ctl #(.AW(5), .DW(32), .WBUF(2)) dutA (
        .clk(clk), .reset(reset), .state_decode(stateDecode),
        .state_write(stateWrite), .ir_msel(irMsel), .ir_madr(irMadr),
        .destm(destm), .wadr(wadr), .wdata(wdata),
        .srcm(srcmA), .mpassm(mpassmA), .mem_adr(memAdrA),
        .mem_rp(memRpA), .mem_wp(memWpA), .mem_wdata(memWdataA),
        .mem_rdata(memRdataA), .mdata(mdataA), .mdata_vld(mdataVldA),
        .wbuf_count(wbufCountA), .wbuf_full(wbufFullA), .stall(stallA)
    );

    mmem_ctl #(.AW(5), .DW(32), .WBUF(3)) dutB (
        .clk(clk), .reset(reset), .state_decode(stateDecode),
        .state_write(stateWrite), .ir_msel(irMsel), .ir_madr(irMadr),
        .destm(destm), .wadr(wadr), .wdata(wdata),
        .srcm(srcmB), .mpassm(mpassmB), .mem_adr(memAdrB),
        .mem_rp(memRpB), .mem_wp(memWpB), .mem_wdata(memWdataB),
        .mem_rdata(memRdataB), .mdata(mdataB), .mdata_vld(mdataVldB),
        .wbuf_count(wbufCountB), .wbuf_full(wbufFullB), .stall(stallB)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM models: write on mem_wp, read data one cycle after mem_rp.
    always @(posedge clk) begin
        if (memWpA) ramA[memAdrA] <= memWdataA;
        if (memRpA) memRdataA <= ramA[memAdrA];
    end

    always @(posedge clk) begin
        if (memWpB) ramB[memAdrB] <= memWdataB;
        if (memRpB) memRdataB <= ramB[memAdrB];
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's worth of request inputs.
    task automatic applyStimulus(input logic dec, input logic wr, input logic dm,
                                 input logic [4:0] madr, input logic [4:0] wa,
                                 input logic [31:0] wd);
        stateDecode = dec;
        stateWrite  = wr;
        destm       = dm;
        irMadr      = madr;
        wadr        = wa;
        wdata       = wd;
    endtask

    // Advances one clock and settles just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Golden occupancy model for the three-entry instance.
    task automatic modelCycle(input logic dec, input logic wr);
        logic drainM;
        logic acceptM;
        drainM  = !dec && (cntModel > 0);
        acceptM = wr && !((cntModel == 3) && dec);
        cntModel = cntModel + int'(acceptM) - int'(drainM);
    endtask

    // Main directed sequence.
    initial begin
        for (int i = 0; i < 32; i++) begin
            ramA[i] = '0;
            ramB[i] = '0;
        end
        memRdataA = '0;
        memRdataB = '0;
        reset  = 1'b0;
        irMsel = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;

        // Reset values; the read strobe still follows state_decode.
        applyStimulus(1, 0, 0, 5, 0, 0);
        #1;
        checkOutput("rst_mem_rp", 32'(memRpA), 32'd1);
        step();
        step();
        checkOutput("rst_count", 32'(wbufCountA), 32'd0);
        checkOutput("rst_full", 32'(wbufFullA), 32'd0);
        checkOutput("rst_vld", 32'(mdataVldA), 32'd0);
        checkOutput("rst_mdata", mdataA, 32'd0);
        checkOutput("rst_mem_wp", 32'(memWpA), 32'd0);
        checkOutput("rst_stall", 32'(stallA), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        ramA[5]  = 32'h1234;
        ramA[12] = 32'h600D;

        // Plain read from RAM.
        applyStimulus(1, 0, 0, 5, 0, 0);
        #1;
        checkOutput("rd_mem_rp", 32'(memRpA), 32'd1);
        checkOutput("rd_mem_adr", 32'(memAdrA), 32'd5);
        checkOutput("rd_mem_wp", 32'(memWpA), 32'd0);
        checkOutput("rd_srcm", 32'(srcmA), 32'd1);
        checkOutput("rd_mpassm", 32'(mpassmA), 32'd1);
        step();
        checkOutput("rd_vld", 32'(mdataVldA), 32'd1);
        checkOutput("rd_mdata", mdataA, 32'h1234);
        applyStimulus(0, 0, 0, 5, 0, 0);
        step();
        checkOutput("rd_vld_drop", 32'(mdataVldA), 32'd0);
        irMsel = 1'b1;
        #1;
        checkOutput("msel_srcm", 32'(srcmA), 32'd0);
        checkOutput("msel_mpassm", 32'(mpassmA), 32'd0);
        irMsel = 1'b0;

        // Two writes to the same address under continuous reads.
        applyStimulus(1, 1, 1, 3, 3, 32'hAAAA);
        step();
        checkOutput("byp_mdata1", mdataA, 32'hAAAA);
        checkOutput("byp_count1", 32'(wbufCountA), 32'd1);
        applyStimulus(1, 1, 1, 3, 3, 32'hBBBB);
        step();
        checkOutput("byp_mdata2", mdataA, 32'hBBBB);
        checkOutput("byp_count2", 32'(wbufCountA), 32'd2);
        checkOutput("byp_full", 32'(wbufFullA), 32'd1);
        applyStimulus(1, 0, 0, 3, 0, 0);
        step();
        checkOutput("byp_mdata3", mdataA, 32'hBBBB);
        checkOutput("byp_ram_untouched", ramA[3], 32'd0);

        // Full buffer: read plus write stalls; write-only drains and accepts.
        applyStimulus(1, 1, 1, 3, 9, 32'hCCCC);
        #1;
        checkOutput("stall_on", 32'(stallA), 32'd1);
        step();
        checkOutput("stall_count", 32'(wbufCountA), 32'd2);
        applyStimulus(0, 1, 1, 3, 9, 32'hCCCC);
        #1;
        checkOutput("wo_stall", 32'(stallA), 32'd0);
        checkOutput("wo_mem_wp", 32'(memWpA), 32'd1);
        checkOutput("wo_mem_adr", 32'(memAdrA), 32'd3);
        checkOutput("wo_mem_wdata", memWdataA, 32'hAAAA);
        step();
        checkOutput("wo_count", 32'(wbufCountA), 32'd2);
        applyStimulus(0, 0, 0, 3, 0, 0);
        #1;
        checkOutput("drain2_wdata", memWdataA, 32'hBBBB);
        step();
        checkOutput("drain2_count", 32'(wbufCountA), 32'd1);
        checkOutput("drain2_ram3", ramA[3], 32'hBBBB);
        step();
        checkOutput("drain3_count", 32'(wbufCountA), 32'd0);
        checkOutput("drain3_ram9", ramA[9], 32'hCCCC);

        // Same-cycle read and write to one address.
        applyStimulus(1, 1, 1, 7, 7, 32'h55);
        step();
        checkOutput("same_mdata", mdataA, 32'h55);
        checkOutput("same_vld", 32'(mdataVldA), 32'd1);
        checkOutput("same_count", 32'(wbufCountA), 32'd1);
        checkOutput("same_ram_pending", ramA[7], 32'd0);
        applyStimulus(0, 0, 0, 7, 0, 0);
        step();
        checkOutput("same_drained", 32'(wbufCountA), 32'd0);
        checkOutput("same_ram7", ramA[7], 32'h55);

        // Reset with two entries buffered discards them.
        applyStimulus(1, 1, 1, 0, 12, 32'h1111);
        step();
        applyStimulus(1, 1, 1, 0, 13, 32'h2222);
        step();
        checkOutput("mid_count_pre", 32'(wbufCountA), 32'd2);
        applyStimulus(0, 0, 0, 12, 0, 0);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_count", 32'(wbufCountA), 32'd0);
        checkOutput("mid_rst_wp", 32'(memWpA), 32'd0);
        checkOutput("mid_rst_vld", 32'(mdataVldA), 32'd0);
        step();
        step();
        checkOutput("mid_rst_ram12", ramA[12], 32'h600D);
        checkOutput("mid_rst_ram13", ramA[13], 32'd0);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 12, 0, 0);
        step();
        checkOutput("post_rst_mdata", mdataA, 32'h600D);
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();

        // Ten writes through the three-entry buffer, interleaved with idles.
        cntModel = 0;
        for (int i = 0; i < 10; i++) begin
            logic dec;
            dec = (cntModel < 3);
            applyStimulus(dec, 1, 1, 0, 5'(16 + i), 32'(256 + i));
            modelCycle(dec, 1'b1);
            step();
            checkOutput("wrap_count", 32'(wbufCountB), 32'(cntModel));
            if (i % 2 == 1) begin
                applyStimulus(0, 0, 0, 0, 0, 0);
                modelCycle(1'b0, 1'b0);
                step();
                checkOutput("wrap_idle_count", 32'(wbufCountB), 32'(cntModel));
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) step();
        checkOutput("wrap_empty", 32'(wbufCountB), 32'd0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("wrap_ram", ramB[16 + i], 32'(256 + i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
